// File: rtl/core_pkg.sv
// Shared core types: word-address program counter and instruction word.
package core_pkg;
    localparam int PC_W   = 30;
    localparam int INST_W = 32;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;
endpackage

// File: rtl/ifetch.sv
// Instruction fetch: sequential PC, one in-flight memory read, one-entry skid buffer.
// Define IFETCH_PERF_EN to add fetched/stall/redirect performance counters.
module ifetch
    import core_pkg::*;
#(
    parameter pc_t RESET_PC = 30'h0
)
(
    input  logic  clk,
    input  logic  rst_n,
    output pc_t   imem_pc,
    input  inst_t imem_inst,
    input  logic  redirect_valid,
    input  pc_t   redirect_pc,
    output logic  out_valid,
    input  logic  out_ready,
    output inst_t out_inst,
    output pc_t   out_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_redirect
`endif
);

    pc_t   pc_q;
    logic  inflight_v_q;
    pc_t   inflight_pc_q;
    logic  skid_v_q;
    pc_t   skid_pc_q;
    inst_t skid_inst_q;

    logic  issue;
    logic  skid_load;
    logic  skid_drain;

    assign imem_pc    = pc_q;
    assign out_valid  = skid_v_q | inflight_v_q;
    assign out_inst   = skid_v_q ? skid_inst_q : imem_inst;
    assign out_pc     = skid_v_q ? skid_pc_q   : inflight_pc_q;

    // A new read is issued whenever the word currently on the output will not be left stranded.
    assign issue      = out_ready | ~out_valid;
    assign skid_load  = inflight_v_q & ~skid_v_q & ~out_ready;
    assign skid_drain = skid_v_q & out_ready;

    // Control state: reset beats redirect, redirect beats normal flow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            inflight_v_q <= 1'b0;
            skid_v_q     <= 1'b0;
        end else if (redirect_valid) begin
            pc_q         <= redirect_pc;
            inflight_v_q <= 1'b0;
            skid_v_q     <= 1'b0;
        end else begin
            inflight_v_q <= issue;
            if (issue) begin
                pc_q <= pc_q + 30'd1;
            end
            if (skid_load) begin
                skid_v_q <= 1'b1;
            end else if (skid_drain) begin
                skid_v_q <= 1'b0;
            end
        end
    end

    // Data payloads carry no reset; their valid bits above qualify them.
    always_ff @(posedge clk) begin
        if (issue) begin
            inflight_pc_q <= pc_q;
        end
        if (skid_load) begin
            skid_pc_q   <= inflight_pc_q;
            skid_inst_q <= imem_inst;
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched  <= 32'd0;
            perf_stall    <= 32'd0;
            perf_redirect <= 32'd0;
        end else begin
            if (out_valid & out_ready) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (out_valid & ~out_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect <= perf_redirect + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios followed by a random ready/redirect/reset run.
module tb_ifetch;
    import core_pkg::*;

    localparam pc_t RP = 30'h0;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    pc_t   imem_pc;
    inst_t imem_inst;
    logic  redirect_valid = 1'b0;
    pc_t   redirect_pc = '0;
    logic  out_valid;
    logic  out_ready = 1'b0;
    inst_t out_inst;
    pc_t   out_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_redirect;
    logic [31:0] m_fetched, m_stall, m_redirect;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the stream is consecutive word addresses from the last restart point.
    bit   known = 1'b0;
    int   since_restart = 0;
    pc_t  exp_pc = '0;
    bit   after_reset = 1'b0;
    bit   exp_valid;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(RP)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
        .perf_redirect  (perf_redirect)
`endif
    );

    function automatic inst_t rom(input pc_t a);
        return (32'h9E37_79B9 * {2'b00, a}) ^ {a, 2'b11};
    endfunction

    // Synchronous instruction memory: data for the address sampled at an edge appears after it.
    always_ff @(posedge clk) imem_inst <= rom(imem_pc);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic rv, input pc_t rpc, input logic rn);
        bit v;
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        rst_n          = rn;
        #1;
        v = known && (since_restart >= 2);
        if (known) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, v});
            if (v) begin
                chk("out_pc", {2'b00, out_pc}, {2'b00, exp_pc});
                chk("out_inst", out_inst, rom(exp_pc));
            end
            if (after_reset) chk("imem_pc_reset", {2'b00, imem_pc}, {2'b00, RP});
        end
        @(posedge clk);
`ifdef IFETCH_PERF_EN
        if (!rn) begin
            m_fetched = 0; m_stall = 0; m_redirect = 0;
        end else begin
            if (v && rdy)  m_fetched++;
            if (v && !rdy) m_stall++;
            if (rv)        m_redirect++;
        end
`endif
        after_reset = 1'b0;
        if (!rn) begin
            known = 1'b1; since_restart = 1; exp_pc = RP; after_reset = 1'b1;
        end else if (rv) begin
            since_restart = 1; exp_pc = rpc;
        end else begin
            if (v && rdy) exp_pc = exp_pc + 30'd1;
            if (since_restart < 2) since_restart++;
        end
        exp_valid = known && (since_restart >= 2);
        #1;
    endtask

    task automatic chk_perf(input string tag);
`ifdef IFETCH_PERF_EN
        chk({tag, "_fetched"},  perf_fetched,  m_fetched);
        chk({tag, "_stall"},    perf_stall,    m_stall);
        chk({tag, "_redirect"}, perf_redirect, m_redirect);
`else
        if (tag.len() == 0) $display("perf counters not built");
`endif
    endtask

    initial begin
        bit   reached;
        logic rdy, rv, rn;
        pc_t  rpc;

        // Reset held for a few cycles, then streaming with out_ready high.
        repeat (3) cyc(1'b1, 1'b0, '0, 1'b0);
        chk_perf("perf_reset");
        repeat (6) cyc(1'b1, 1'b0, '0, 1'b1);

        // Advance to out_pc 5, then stall three cycles.
        reached = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            if (out_valid && out_pc == 30'd5) reached = 1'b1;
            else cyc(1'b1, 1'b0, '0, 1'b1);
        end
        chk("reach_pc5", {31'b0, reached}, 32'd1);
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);
        repeat (4) cyc(1'b1, 1'b0, '0, 1'b1);

        // Redirect while streaming.
        cyc(1'b1, 1'b1, 30'h40, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, '0, 1'b1);

        // Redirect with the skid buffer full.
        repeat (3) cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b1, 30'h10, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, '0, 1'b1);

        // Wrap-around at the top of the address space.
        cyc(1'b1, 1'b1, 30'h3FFF_FFFF, 1'b1);
        repeat (5) cyc(1'b1, 1'b0, '0, 1'b1);

        // Reset pulse in the middle of a stall.
        repeat (2) cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk_perf("perf_midreset");
        repeat (5) cyc(1'b1, 1'b0, '0, 1'b1);

        // Random ready, redirects and occasional resets.
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE : pc_t'($urandom());
            rn  = ($urandom_range(0, 99) != 0);
            cyc(rdy, rv, rpc, rn);
        end
        chk_perf("perf_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 30'h0, word address fetched first after reset.
REQ-002 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port imem_pc  out  30  word address to instruction memory; imem_pc equals pc_q directly, with no combinational input path.
REQ-005 SHALL have port imem_inst  in  32  memory read data, valid one cycle after the address is sampled.
REQ-006 SHALL have port redirect_valid  in  1  branch/jump redirect request.
REQ-007 SHALL have port redirect_pc  in  30  redirect target word address.
REQ-008 SHALL have port out_valid  out  1  instruction available to decode.
REQ-009 SHALL have port out_ready  in  1  decode accepts this cycle.
REQ-010 SHALL have port out_inst  out  32  instruction word.
REQ-011 SHALL have port out_pc  out  30  word address of out_inst.

Function
REQ-012 SHALL hold state pc_q (next address), inflight_v_q/inflight_pc_q (word on imem_inst this cycle), and skid_v_q/skid_pc_q/skid_inst_q (one-entry skid buffer).
REQ-013 SHALL drive out_valid = skid_v_q | inflight_v_q; on skid_v_q, out_inst/out_pc = skid entry, else imem_inst/inflight_pc_q.
REQ-014 SHALL issue when issue = out_ready | ~out_valid; on issue: inflight_v_q<=1, inflight_pc_q<=pc_q, pc_q<=pc_q+1 modulo 2^30 (3FFFFFFF wraps to 0); otherwise inflight_v_q<=0 and pc_q holds.
REQ-015 SHALL capture imem_inst/inflight_pc_q into the skid entry when inflight_v_q & ~skid_v_q & ~out_ready.
REQ-016 SHALL clear skid_v_q when skid_v_q & out_ready.
REQ-017 SHALL never have skid_v_q and inflight_v_q both set; sustained out_ready gives one instruction per cycle.
REQ-018 SHALL, on redirect_valid, set pc_q<=redirect_pc and clear inflight_v_q and skid_v_q, overriding REQ-014..016.
REQ-019 SHALL leave out_valid unmasked in the redirect cycle; a handshake in that cycle completes normally.
REQ-020 SHALL present the redirect target with out_valid two cycles after the redirect cycle, given out_ready held high.
REQ-021 SHALL keep out_inst/out_pc stable while out_valid & ~out_ready, absent redirect.

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge, set pc_q=RESET_PC, inflight_v_q=0, skid_v_q=0, so out_valid=0 and imem_pc=RESET_PC.
REQ-023 SHALL make reset override redirect and clear any in-flight or skid contents mid-operation.
REQ-024 SHALL assert out_valid with out_pc=RESET_PC in the second cycle after rst_n rises.

Configuration
REQ-025 SHALL, with IFETCH_PERF_EN defined, add outputs perf_fetched (32), perf_stall (32), perf_redirect (32), all reset to 0.
REQ-026 SHALL have perf_fetched count out_valid&out_ready cycles, perf_stall count out_valid&~out_ready cycles, and perf_redirect count redirect_valid cycles; all wrap modulo 2^32.
REQ-027 SHALL, without IFETCH_PERF_EN, omit these ports and their logic entirely.

Structure
REQ-028 SHALL import pc_t (logic [29:0]) and inst_t (logic [31:0]) from shared package core_pkg.
REQ-029 SHALL keep the skid logic inline; no sub-module is required.

Verification
REQ-030 SHALL verify reset release with RESET_PC=0 and out_ready=1: outputs are out_pc 0,1,2,3 on consecutive cycles, out_inst matching the ROM.
REQ-031 SHALL verify stall: drop out_ready for 3 cycles while out_pc=5; out_pc/out_inst hold at 5, then 6 follows with no loss or duplicate.
REQ-032 SHALL verify redirect: redirect_valid with redirect_pc=0x40 while streaming; out_pc=0x40 appears 2 cycles later, no stale words in between.
REQ-033 SHALL verify redirect during stall: skid full, redirect_pc=0x10; skid is flushed, next out_pc=0x10.
REQ-034 SHALL verify wrap-around: redirect to 0x3FFFFFFF; outputs are 0x3FFFFFFF then 0x0.
REQ-035 SHALL verify mid-run reset: rst_n low one cycle during a stall; out_valid=0 the next cycle and fetch restarts at RESET_PC; perf counters are 0 when IFETCH_PERF_EN is defined.
